fetch_unit: RTL and testbench
=============================

# fetch_unit

Pipeline front end for the five-stage MIPS core: holds the program counter, addresses instruction memory, and registers the fetched word into the IF/ID boundary. It sits directly upstream of the D-stage branch comparator. It feeds that comparator the D-stage instruction. It consumes the comparator's taken flag and the D-stage next-PC selection to redirect fetch. Branches and jumps resolve in D with one architectural delay slot, so no flush path exists.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_3000, first fetch address after reset.
- `IM_WORDS`, default 4096, instruction memory depth in words.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `stall`  in  1  hazard-unit freeze of PC and IF/ID.
- `npc_sel`  in  2  D-stage next-PC select: 0 SEQ, 1 BR, 2 J (j/jal), 3 JR (jr/jalr).
- `br_taken`  in  1  D-stage comparator result; meaningful only when `npc_sel`=BR.
- `rs_data_d`  in  32  forwarded rs value in D; JR target.
- `instr_f`  in  32  instruction memory read data for `im_addr`, combinational.
- `im_addr`  out  log2(IM_WORDS)  word index (`pc_f - PC_RESET`)>>2.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  IF/ID instruction.
- `pc_d`  out  32  IF/ID PC.
- `pc8_d`  out  32  IF/ID link value `pc_d`+8.
- `pc_err`  out  1  one-cycle pulse: attempted PC load misaligned or out of range.

## Operation
- Next PC, computed from IF/ID contents:
  - SEQ: `pc_f`+4.
  - BR: if `br_taken`, `pc_d`+4+(sign-extended `instr_d[15:0]`<<2). Otherwise `pc_f`+4.
  - J: {`pc_d`+4 [31:28], `instr_d[25:0]`, 2'b00}.
  - JR: `rs_data_d`.
- Priority: reset > stall > `npc_sel`. While `stall`=1, PC and IF/ID all hold, and `npc_sel` and `br_taken` are ignored. The D instruction re-evaluates its redirect once the stall drops.
- Delay slot: the word in F when a redirect resolves is latched into IF/ID normally. The target is fetched next cycle.
- Range check: valid PC means word-aligned and within [`PC_RESET`, `PC_RESET`+4·`IM_WORDS`).
  - An invalid next PC is not loaded. PC takes `pc_f`+4 instead, and `pc_err` pulses for that cycle.
  - If `pc_f` itself is out of range, IF/ID latches 32'h0 (nop) instead of `instr_f`.
- All arithmetic is 32-bit modulo; carries out of bit 31 are dropped.

## Timing
- Reset values:
  - `pc_f` = `PC_RESET`
  - `instr_d` = 0
  - `pc_d` = 0
  - `pc8_d` = 8
  - `pc_err` = 0
- `im_addr` and the next-PC mux are combinational. PC and IF/ID update on the same edge.
- Latency: a word at `pc_f` appears on `instr_d` one cycle later. A redirect decided in D in cycle n fetches the target in cycle n+1. The delay slot occupies D in cycle n+1.
- Reset asserted mid-stall or mid-redirect wins: state returns to reset values on that edge.
- Stall and redirect in the same cycle: the redirect is deferred, not lost.
- `pc_err` is combinational from the candidate PC, gated by !`stall` and reset-deasserted.

## Structure
- Constants in shared `settings.v`:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR codes.
  - `PC_RESET` default.
  - Existing opcode macros.
- Sub-module `npc_calc` (combinational): inputs `npc_sel`, `br_taken`, `pc_f`, `pc_d`, `instr_d`, `rs_data_d`. Outputs candidate next PC.
- Top level holds the PC register, range check, and IF/ID register.

## Test plan
- Reset then release, memory returns 32'h2408_0001, 32'h2409_0002 → `pc_f` 3000, 3004, 3008. `instr_d` 0, 24080001, 24090002. `pc8_d`=3008 when `pc_d`=3000.
- beq with `instr_d`=32'h1000_0003 at `pc_d`=3004, `npc_sel`=BR, `br_taken`=1 → delay slot 3008 enters IF/ID, next `pc_f`=3014. With `br_taken`=0 → `pc_f`=300C.
- j with `instr_d`=32'h0800_0C10 at `pc_d`=3000 → `pc_f`=3040 after the delay-slot fetch. jr with `rs_data_d`=32'h0000_3100 → `pc_f`=3100.
- `stall`=1 for 2 cycles while `npc_sel`=BR and `br_taken`=1 → `pc_f`, `instr_d` and `pc_d` frozen. On release the branch redirects exactly once.
- jr to 32'h0000_3102, then jr to 32'h0000_0000 → `pc_err` pulses each time, `pc_f` advances by 4, no illegal load.
- Drive reset low during a taken branch with `stall`=1 → next edge `pc_f`=3000, `instr_d`=0, `pc_err`=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch front end: next-PC select codes, reset PC and
// the PC range check used by both the PC load and the instruction-valid gate.
package fetch_unit_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Offset from the base wraps for pc < base, so one unsigned compare covers both bounds.
    function automatic logic pc_in_range(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] bytes);
        logic [31:0] off;
        off = pc - base;
        return (off[1:0] == 2'b00) && (off < bytes);
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC candidate from the D-stage redirect request; range
// checking is left to the top level.
module fetch_unit_npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  logic [31:0] rs_data_d,
    output logic [31:0] npc
);

    logic [31:0] pc_seq;
    logic [31:0] pc_d4;
    logic [31:0] br_off;
    logic        unused_opcode;

    assign pc_seq = pc_f + 32'd4;
    assign pc_d4  = pc_d + 32'd4;
    assign br_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign unused_opcode = &{1'b0, instr_d[31:26]};

    always_comb begin
        npc = pc_seq;
        case (npc_sel)
            NPC_SEQ: npc = pc_seq;
            NPC_BR:  npc = br_taken ? (pc_d4 + br_off) : pc_seq;
            NPC_J:   npc = {pc_d4[31:28], instr_d[25:0], 2'b00};
            NPC_JR:  npc = rs_data_d;
            default: npc = pc_seq;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction memory addressing and the IF/ID
// boundary register. Redirects resolve in D with one delay slot, so no flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [1:0]                  npc_sel,
    input  logic                        br_taken,
    input  logic [31:0]                 rs_data_d,
    input  logic [31:0]                 instr_f,
    output logic [$clog2(IM_WORDS)-1:0] im_addr,
    output logic [31:0]                 pc_f,
    output logic [31:0]                 instr_d,
    output logic [31:0]                 pc_d,
    output logic [31:0]                 pc8_d,
    output logic                        pc_err
);

    localparam int          AW       = $clog2(IM_WORDS);
    localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;

    logic [31:0] pc_off;
    logic [31:0] pc_seq;
    logic [31:0] npc_cand;
    logic        cand_ok;
    logic        fetch_ok;

    assign pc_off   = pc_f - PC_RESET;
    assign im_addr  = pc_off[AW+1:2];
    assign pc_seq   = pc_f + 32'd4;
    assign fetch_ok = pc_in_range(pc_f, PC_RESET, IM_BYTES);
    assign cand_ok  = pc_in_range(npc_cand, PC_RESET, IM_BYTES);
    assign pc_err   = reset && !stall && !cand_ok;

    fetch_unit_npc_calc u_npc_calc (
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .pc_f      (pc_f),
        .pc_d      (pc_d),
        .instr_d   (instr_d),
        .rs_data_d (rs_data_d),
        .npc       (npc_cand)
    );

    // An illegal candidate falls back to sequential fetch instead of loading.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f    <= PC_RESET;
            instr_d <= 32'h0;
            pc_d    <= 32'h0;
            pc8_d   <= 32'd8;
        end else if (!stall) begin
            pc_f    <= cand_ok ? npc_cand : pc_seq;
            instr_d <= fetch_ok ? instr_f : 32'h0;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized check of fetch_unit against a behavioural model of the fetch
// rules (redirect targets, range fallback, stall hold, nop on bad fetch).
module tb_fetch_unit;

    localparam logic [31:0] PCR   = 32'h0000_3000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] rs_data_d;
    logic [31:0] instr_f;
    logic [11:0] im_addr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        pc_err;

    logic [31:0] mem [0:WORDS-1];

    int n_vec  = 0;
    int n_miss = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;

    always #5 clk = ~clk;

    assign instr_f = mem[im_addr];

    fetch_unit #(.PC_RESET(PCR), .IM_WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .rs_data_d (rs_data_d),
        .instr_f   (instr_f),
        .im_addr   (im_addr),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .pc_err    (pc_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a % 4 == 0) && (ua >= longint'(PCR)) && (ua < longint'(PCR) + 4 * WORDS);
    endfunction

    task automatic cycle(input logic rst, input logic st, input logic [1:0] sel,
                         input logic bt, input logic [31:0] rs);
        logic [31:0] target, fetched;
        logic        err;
        @(negedge clk);
        reset = rst; stall = st; npc_sel = sel; br_taken = bt; rs_data_d = rs;
        #1;
        fetched = legal(m_pc) ? mem[(m_pc - PCR) / 4] : 32'h0;
        case (sel)
            2'd1:    target = bt ? m_pcd + 4 + 4 * 32'($signed(m_instr[15:0])) : m_pc + 4;
            2'd2:    target = ((m_pcd + 4) & 32'hF000_0000) | ({6'd0, m_instr[25:0]} * 4);
            2'd3:    target = rs;
            default: target = m_pc + 4;
        endcase
        err = rst && !st && !legal(target);
        chk("pc_f", pc_f, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("pc8_d", pc8_d, m_pc8);
        chk("im_addr", {20'd0, im_addr}, ((m_pc - PCR) / 4) % WORDS);
        chk("pc_err", {31'd0, pc_err}, {31'd0, err});
        @(posedge clk);
        if (!rst) begin
            m_pc = PCR; m_instr = 0; m_pcd = 0; m_pc8 = 8;
        end else if (!st) begin
            m_instr = fetched;
            m_pcd   = m_pc;
            m_pc8   = m_pc + 8;
            m_pc    = legal(target) ? target : m_pc + 4;
        end
    endtask

    initial begin
        logic [15:0] lo;
        logic [31:0] rs;
        int          r;
        for (int i = 0; i < WORDS; i++) begin
            if ($urandom_range(0, 1) == 1)
                lo = 16'($urandom_range(16'h0C00, 16'h1BFF));
            else
                lo = 16'(int'($urandom_range(0, 32)) - 16);
            mem[i] = {6'($urandom), 10'd0, lo};
        end
        mem[0] = 32'h2408_0001;
        mem[1] = 32'h1000_0003;
        mem[2] = 32'h2409_0002;

        reset = 1'b0; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0; rs_data_d = 32'h0;
        repeat (2) @(posedge clk);
        m_pc = PCR; m_instr = 0; m_pcd = 0; m_pc8 = 8;

        // Directed: sequential fetch, stalled taken beq, jr errors, reset during stall
        cycle(1, 0, 2'd0, 0, 0);
        cycle(1, 0, 2'd0, 0, 0);
        cycle(1, 1, 2'd1, 1, 0);
        cycle(1, 1, 2'd1, 1, 0);
        cycle(1, 0, 2'd1, 1, 0);
        cycle(1, 0, 2'd0, 0, 0);
        cycle(1, 0, 2'd3, 0, 32'h0000_3102);
        cycle(1, 0, 2'd3, 0, 32'h0000_0000);
        cycle(1, 0, 2'd3, 0, 32'h0000_3100);
        cycle(1, 0, 2'd2, 0, 0);
        cycle(0, 1, 2'd1, 1, 0);
        cycle(1, 0, 2'd0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 3));
            if (r < 2)       rs = PCR + 4 * $urandom_range(0, WORDS - 1);
            else if (r == 2) rs = PCR + $urandom_range(0, 4 * WORDS - 1);
            else             rs = $urandom;
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                  2'($urandom), 1'($urandom), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
